// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and lane helpers for the AXI-Lite load/store master
package lsu_pkg;

   localparam int LSU_LANES = 8;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } access_size_e;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      RESP    = 3'd5
   } lsu_state_e;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] size_mask(input access_size_e size);
      case (size)
         BYTE:    size_mask = 3'b000;
         HALF:    size_mask = 3'b001;
         WORD:    size_mask = 3'b011;
         default: size_mask = 3'b111;
      endcase
   endfunction

   function automatic logic [LSU_LANES-1:0] lane_mask(input access_size_e size);
      case (size)
         BYTE:    lane_mask = 8'h01;
         HALF:    lane_mask = 8'h03;
         WORD:    lane_mask = 8'h0F;
         default: lane_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/axil_interface_if.sv
// rtl/axil_interface_if.sv - AXI4-Lite bundle with read/write master and slave views
interface axil_interface_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) ();
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport rd_mst (output araddr, arprot, arvalid, rready,
                   input  arready, rdata, rresp, rvalid);
   modport wr_mst (output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                   input  awready, wready, bresp, bvalid);
   modport rd_slv (input  araddr, arprot, arvalid, rready,
                   output arready, rdata, rresp, rvalid);
   modport wr_slv (input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                   output awready, wready, bresp, bvalid);
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]           addr_lo,
   input  access_size_e         size,
   input  logic [63:0]          st_data,
   output logic [2:0]           offset,
   output logic                 misaligned,
   output logic [LSU_LANES-1:0] wstrb,
   output logic [63:0]          wdata,
   input  logic [2:0]           ld_offset,
   input  access_size_e         ld_size,
   input  logic                 ld_unsigned,
   input  logic [63:0]          rdata,
   output logic [63:0]          ld_data
);
   logic [2:0]  mask;
   logic [63:0] shifted;

   always_comb begin
      mask       = size_mask(size);
      misaligned = |(addr_lo & mask);
      // Misaligned offsets are forced down to the natural boundary of the size.
      offset     = addr_lo & ~mask;
      wstrb      = lane_mask(size) << offset;
      wdata      = st_data << {offset, 3'b000};

      shifted = rdata >> {ld_offset, 3'b000};
      case (ld_size)
         BYTE:    ld_data = ld_unsigned ? {56'h0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
         HALF:    ld_data = ld_unsigned ? {48'h0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
         WORD:    ld_data = ld_unsigned ? {32'h0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_axil_master.sv
// rtl/lsu_axil_master.sv - single-outstanding load/store to AXI4-Lite master
// Optional LSU_MISALIGN_CHECK_EN: misaligned requests error out without bus traffic.
module lsu_axil_master
   import lsu_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [63:0]       req_wdata,
   output logic              rsp_valid,
   output logic [63:0]       rsp_data,
   output logic              rsp_err,
   axil_interface_if.rd_mst  axil_rd,
   axil_interface_if.wr_mst  axil_wr
);
   lsu_state_e          state;

   logic [ADDR_W-1:0]   araddr_q;
   logic                arvalid_q;
   logic                rready_q;
   logic [ADDR_W-1:0]   awaddr_q;
   logic                awvalid_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                wvalid_q;
   logic                bready_q;

   logic [2:0]          ld_off_q;
   access_size_e        ld_size_q;
   logic                ld_uns_q;

   logic                rsp_valid_q;
   logic [63:0]         rsp_data_q;
   logic                rsp_err_q;

   logic [2:0]          req_off;
   logic                req_misaligned;
   logic [7:0]          st_wstrb;
   logic [63:0]         st_wdata;
   logic [63:0]         ld_data;
   logic [ADDR_W-1:0]   bus_addr;
   logic                aw_pending;
   logic                w_pending;

   lsu_lane_align u_align (
      .addr_lo     (req_addr[2:0]),
      .size        (access_size_e'(req_size)),
      .st_data     (req_wdata),
      .offset      (req_off),
      .misaligned  (req_misaligned),
      .wstrb       (st_wstrb),
      .wdata       (st_wdata),
      .ld_offset   (ld_off_q),
      .ld_size     (ld_size_q),
      .ld_unsigned (ld_uns_q),
      .rdata       (axil_rd.rdata),
      .ld_data     (ld_data)
   );

   assign bus_addr   = {req_addr[ADDR_W-1:3], 3'b000};
   assign aw_pending = awvalid_q && !axil_wr.awready;
   assign w_pending  = wvalid_q && !axil_wr.wready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         ld_off_q    <= 3'd0;
         ld_size_q   <= BYTE;
         ld_uns_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 64'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  ld_off_q  <= req_off;
                  ld_size_q <= access_size_e'(req_size);
                  ld_uns_q  <= req_unsigned;
`ifdef LSU_MISALIGN_CHECK_EN
                  if (req_misaligned) begin
                     state       <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= 64'h0;
                  end else
`endif
                  if (req_store) begin
                     state     <= WR_REQ;
                     awaddr_q  <= bus_addr;
                     awvalid_q <= 1'b1;
                     wdata_q   <= st_wdata;
                     wstrb_q   <= st_wstrb;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state     <= RD_ADDR;
                     araddr_q  <= bus_addr;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            RD_ADDR: begin
               if (axil_rd.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (axil_rd.rvalid) begin
                  rready_q    <= 1'b0;
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= (axil_rd.rresp != OKAY);
                  rsp_data_q  <= (axil_rd.rresp == OKAY) ? ld_data : 64'h0;
               end
            end
            WR_REQ: begin
               // AW and W complete independently; B waits for whichever finishes last.
               if (awvalid_q && axil_wr.awready) awvalid_q <= 1'b0;
               if (wvalid_q && axil_wr.wready)   wvalid_q  <= 1'b0;
               if (!aw_pending && !w_pending) begin
                  bready_q <= 1'b1;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axil_wr.bvalid) begin
                  bready_q    <= 1'b0;
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= (axil_wr.bresp != OKAY);
                  rsp_data_q  <= 64'h0;
               end
            end
            RESP: begin
               state      <= IDLE;
               rsp_err_q  <= 1'b0;
               rsp_data_q <= 64'h0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   assign axil_rd.araddr  = araddr_q;
   assign axil_rd.arprot  = 3'b000;
   assign axil_rd.arvalid = arvalid_q;
   assign axil_rd.rready  = rready_q;

   assign axil_wr.awaddr  = awaddr_q;
   assign axil_wr.awprot  = 3'b000;
   assign axil_wr.awvalid = awvalid_q;
   assign axil_wr.wdata   = wdata_q;
   assign axil_wr.wstrb   = wstrb_q;
   assign axil_wr.wvalid  = wvalid_q;
   assign axil_wr.bready  = bready_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
// tb/tb_lsu_axil_master.sv - table-driven scoreboard bench for lsu_axil_master
module tb_lsu_axil_master;

   typedef struct {
      logic        st;
      logic [63:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [63:0] wd;
      logic [63:0] rd;
      logic [1:0]  resp;
      int          aw_w;
      int          w_w;
      int          ar_w;
      int          r_w;
      int          b_w;
      logic        axi;
      logic [63:0] exp_addr;
      logic [7:0]  exp_strb;
      logic [63:0] exp_wdata;
      logic [63:0] exp_data;
      logic        exp_err;
      int          exp_cyc;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [63:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_wdata = '0;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic        rsp_err;

   axil_interface_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   lsu_axil_master #(.DATA_W(64), .ADDR_W(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_store    (req_store),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .axil_rd      (bus),
      .axil_wr      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   rsp_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Slave model configuration and observations
   int          cfg_aw_w, cfg_w_w, cfg_ar_w, cfg_r_w, cfg_b_w;
   logic [63:0] cfg_rdata;
   logic [1:0]  cfg_resp;
   int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   int          ar_seen, aw_seen, aw_stall, w_high;
   logic [63:0] last_araddr, last_awaddr, last_wdata;
   logic [7:0]  last_wstrb;

   initial begin
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
      cfg_aw_w = 0; cfg_w_w = 0; cfg_ar_w = 0; cfg_r_w = 0; cfg_b_w = 0;
      cfg_rdata = '0; cfg_resp = '0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_seen = 0; aw_seen = 0; aw_stall = 0; w_high = 0;
      last_araddr = '0; last_awaddr = '0; last_wdata = '0; last_wstrb = '0;
   end

   always @(negedge clk) begin
      if (bus.arvalid) begin
         ar_seen++; last_araddr = bus.araddr;
         if (ar_cnt < cfg_ar_w) begin bus.arready = 1'b0; ar_cnt++; end
         else bus.arready = 1'b1;
      end else begin bus.arready = 1'b0; ar_cnt = 0; end

      if (bus.rready) begin
         if (r_cnt < cfg_r_w) begin bus.rvalid = 1'b0; r_cnt++; end
         else begin bus.rvalid = 1'b1; bus.rdata = cfg_rdata; bus.rresp = cfg_resp; end
      end else begin bus.rvalid = 1'b0; r_cnt = 0; end

      if (bus.awvalid) begin
         aw_seen++; last_awaddr = bus.awaddr;
         if (aw_cnt < cfg_aw_w) begin bus.awready = 1'b0; aw_cnt++; aw_stall++; end
         else bus.awready = 1'b1;
      end else begin bus.awready = 1'b0; aw_cnt = 0; end

      if (bus.wvalid) begin
         w_high++; last_wdata = bus.wdata; last_wstrb = bus.wstrb;
         if (w_cnt < cfg_w_w) begin bus.wready = 1'b0; w_cnt++; end
         else bus.wready = 1'b1;
      end else begin bus.wready = 1'b0; w_cnt = 0; end

      if (bus.bready) begin
         if (b_cnt < cfg_b_w) begin bus.bvalid = 1'b0; b_cnt++; end
         else begin bus.bvalid = 1'b1; bus.bresp = cfg_resp; end
      end else begin bus.bvalid = 1'b0; b_cnt = 0; end
   end

   // Response scoreboard
   always @(posedge clk) begin
      #1;
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected actual=%h expected=none", rsp_data);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
         end
      end
   end

   task automatic run_vec(input int idx, input vec_t v);
      int cyc;
      bit seen;
      rsp_t e;
      @(negedge clk);
      cfg_aw_w = v.aw_w; cfg_w_w = v.w_w; cfg_ar_w = v.ar_w; cfg_r_w = v.r_w; cfg_b_w = v.b_w;
      cfg_rdata = v.rd; cfg_resp = v.resp;
      ar_seen = 0; aw_seen = 0; aw_stall = 0; w_high = 0;
      req_valid = 1'b1; req_store = v.st; req_addr = v.addr; req_size = v.size;
      req_unsigned = v.uns; req_wdata = v.wd;
      @(posedge clk);
      e.data = v.exp_data; e.err = v.exp_err;
      exp_q.push_back(e);
      #1;
      req_valid = 1'b0;
      cyc = 1; seen = 0;
      while (!seen && cyc < 60) begin
         if (rsp_valid) seen = 1;
         else begin @(posedge clk); #1; cyc++; end
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL rsp_timeout vec=%0d actual=none expected=rsp_valid", idx);
      end else begin
         chk($sformatf("latency_v%0d", idx), 64'(cyc), 64'(v.exp_cyc));
      end
      if (v.axi) begin
         if (v.st) begin
            chk($sformatf("awaddr_v%0d", idx), last_awaddr, v.exp_addr);
            chk($sformatf("wstrb_v%0d", idx), {56'h0, last_wstrb}, {56'h0, v.exp_strb});
            chk($sformatf("wdata_v%0d", idx), last_wdata, v.exp_wdata);
         end else begin
            chk($sformatf("araddr_v%0d", idx), last_araddr, v.exp_addr);
         end
      end else begin
         chk($sformatf("no_axi_v%0d", idx), 64'(ar_seen + aw_seen), 64'd0);
      end
      if (v.aw_w > 0) begin
         chk("awvalid_stall_cycles", 64'(aw_stall), 64'(v.aw_w));
         chk("wvalid_high_cycles", 64'(w_high), 64'(v.w_w + 1));
      end
      @(posedge clk);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{0, 64'h100, 2'd3, 0, 64'h0, 64'h1122334455667788, 2'b00, 0, 0, 0, 0, 0,
                  1, 64'h100, 8'h00, 64'h0, 64'h1122334455667788, 0, 3};
      vecs[1] = '{0, 64'h107, 2'd0, 0, 64'h0, 64'h80AABBCCDDEEFF11, 2'b00, 0, 0, 0, 0, 0,
                  1, 64'h100, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 3};
      vecs[2] = '{0, 64'h107, 2'd0, 1, 64'h0, 64'h80AABBCCDDEEFF11, 2'b00, 0, 0, 0, 0, 0,
                  1, 64'h100, 8'h00, 64'h0, 64'h0000000000000080, 0, 3};
      vecs[3] = '{1, 64'h202, 2'd1, 0, 64'hBEEF, 64'h0, 2'b00, 0, 0, 0, 0, 0,
                  1, 64'h200, 8'h0C, 64'h00000000BEEF0000, 64'h0, 0, 3};
      vecs[4] = '{1, 64'h304, 2'd2, 0, 64'hDEADBEEF, 64'h0, 2'b00, 3, 0, 0, 0, 0,
                  1, 64'h300, 8'hF0, 64'hDEADBEEF00000000, 64'h0, 0, 6};
      vecs[5] = '{0, 64'h600, 2'd2, 1, 64'h0, 64'h12345678, 2'b10, 0, 0, 0, 0, 0,
                  1, 64'h600, 8'h00, 64'h0, 64'h0, 1, 3};
`ifdef LSU_MISALIGN_CHECK_EN
      vecs[6] = '{0, 64'h3, 2'd2, 0, 64'h0, 64'h89ABCDEFF1234567, 2'b00, 0, 0, 0, 0, 0,
                  0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 1};
`else
      vecs[6] = '{0, 64'h3, 2'd2, 0, 64'h0, 64'h89ABCDEFF1234567, 2'b00, 0, 0, 0, 0, 0,
                  1, 64'h0, 8'h00, 64'h0, 64'hFFFFFFFFF1234567, 0, 3};
`endif
      vecs[7] = '{0, 64'h10A, 2'd1, 0, 64'h0, 64'h000000007FFE0000, 2'b00, 0, 0, 0, 2, 0,
                  1, 64'h108, 8'h00, 64'h0, 64'h0000000000007FFE, 0, 5};
      vecs[8] = '{1, 64'h408, 2'd3, 0, 64'h0102030405060708, 64'h0, 2'b11, 0, 0, 0, 0, 1,
                  1, 64'h408, 8'hFF, 64'h0102030405060708, 64'h0, 1, 4};
      vecs[9] = '{1, 64'h505, 2'd0, 0, 64'hA5, 64'h0, 2'b00, 0, 2, 0, 0, 0,
                  1, 64'h500, 8'h20, 64'h0000A50000000000, 64'h0, 0, 5};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_ready", {63'h0, req_ready}, 64'd1);
      chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'd0);
      chk("reset_rsp_data", rsp_data, 64'h0);
      chk("reset_valids", {59'h0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 64'h0);
      chk("reset_wstrb_wdata", bus.wdata | {56'h0, bus.wstrb} | bus.awaddr | bus.araddr, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Reset while arvalid is asserted
      begin
         int rsp_seen;
         @(negedge clk);
         cfg_ar_w = 20;
         req_valid = 1'b1; req_store = 1'b0; req_addr = 64'h700; req_size = 2'd3;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         chk("mid_arvalid_before_rst", {63'h0, bus.arvalid}, 64'd1);
         rst = 1'b1;
         #1;
         chk("mid_arvalid_after_rst", {63'h0, bus.arvalid}, 64'd0);
         @(negedge clk);
         rst = 1'b0;
         cfg_ar_w = 0;
         rsp_seen = 0;
         for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) rsp_seen++;
         end
         chk("mid_rst_no_rsp", 64'(rsp_seen), 64'd0);
         chk("mid_rst_req_ready", {63'h0, req_ready}, 64'd1);
      end

      run_vec(10, vecs[0]);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
